// File: rtl/dram_ctrl_pkg.sv
// rtl/dram_ctrl_pkg.sv - shared state type and default geometry/timing for dram_ctrl
package dram_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ROW,
      S_RAS,
      S_COL,
      S_CAS,
      S_PRE
   } state_t;

   localparam int ROW_W_DEF  = 11;
   localparam int COL_W_DEF  = 11;
   localparam int DATA_W_DEF = 32;
   localparam int T_RCD_DEF  = 1;
   localparam int T_CL_DEF   = 2;
   localparam int T_RP_DEF   = 1;

   // Phase counter counts down to zero, so a T-cycle phase loads T-1.
   function automatic logic [3:0] cnt_load(input int t);
      return 4'(t - 1);
   endfunction

endpackage

// File: rtl/dram_ctrl.sv
// rtl/dram_ctrl.sv - single-access request controller driving DRAM RASn/CASn/WEn/CSn strobes
module dram_ctrl
   import dram_ctrl_pkg::*;
#(
   parameter int ROW_W  = ROW_W_DEF,
   parameter int COL_W  = COL_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int T_RCD  = T_RCD_DEF,
   parameter int T_CL   = T_CL_DEF,
   parameter int T_RP   = T_RP_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_write,
   input  logic [ROW_W+COL_W-1:0] req_addr,
   input  logic [DATA_W-1:0]      req_wdata,
   output logic                   resp_valid,
   output logic [DATA_W-1:0]      resp_rdata,
   output logic                   dram_csn,
   output logic                   dram_rasn,
   output logic                   dram_casn,
   output logic                   dram_wen,
   output logic [ROW_W-1:0]       dram_a,
   output logic [DATA_W-1:0]      dram_d,
   input  logic [DATA_W-1:0]      dram_q
);

   state_t             state;
   logic [3:0]         cnt;
   logic               write_q;
   logic [ROW_W-1:0]   row_q;
   logic [COL_W-1:0]   col_q;
   logic [DATA_W-1:0]  wdata_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         cnt        <= '0;
         write_q    <= 1'b0;
         row_q      <= '0;
         col_q      <= '0;
         wdata_q    <= '0;
         req_ready  <= 1'b0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         dram_csn   <= 1'b1;
         dram_rasn  <= 1'b1;
         dram_casn  <= 1'b1;
         dram_wen   <= 1'b1;
         dram_a     <= '0;
         dram_d     <= '0;
      end else begin
         resp_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               req_ready <= 1'b1;
               if (req_valid && req_ready) begin
                  write_q   <= req_write;
                  row_q     <= req_addr[ROW_W+COL_W-1:COL_W];
                  col_q     <= req_addr[COL_W-1:0];
                  wdata_q   <= req_wdata;
                  req_ready <= 1'b0;
                  dram_csn  <= 1'b0;
                  dram_a    <= req_addr[ROW_W+COL_W-1:COL_W];
                  state     <= S_ROW;
               end
            end
            S_ROW: begin
               dram_rasn <= 1'b0;
               cnt       <= cnt_load(T_RCD);
               state     <= S_RAS;
            end
            S_RAS: begin
               if (cnt == 4'd0) begin
                  // Column and write data go out a full cycle ahead of CASn falling.
                  dram_a   <= ROW_W'(col_q);
                  dram_wen <= ~write_q;
                  dram_d   <= write_q ? wdata_q : '0;
                  state    <= S_COL;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            S_COL: begin
               dram_casn <= 1'b0;
               cnt       <= cnt_load(T_CL);
               state     <= S_CAS;
            end
            S_CAS: begin
               if (cnt == 4'd0) begin
                  if (!write_q) begin
                     resp_rdata <= dram_q;
                  end
                  dram_csn   <= 1'b1;
                  dram_rasn  <= 1'b1;
                  dram_casn  <= 1'b1;
                  dram_wen   <= 1'b1;
                  dram_a     <= '0;
                  dram_d     <= '0;
                  resp_valid <= 1'b1;
                  cnt        <= cnt_load(T_RP);
                  state      <= S_PRE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            S_PRE: begin
               if (cnt == 4'd0) begin
                  req_ready <= 1'b1;
                  state     <= S_IDLE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dram_ctrl.sv
// tb/tb_dram_ctrl.sv - directed self-checking bench for dram_ctrl with a strobe-level DRAM model
module tb_dram_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_valid2 = 1'b0;
   logic        req_write = 1'b0;
   logic [21:0] req_addr = '0;
   logic [31:0] req_wdata = '0;

   logic        req_ready, resp_valid, dram_csn, dram_rasn, dram_casn, dram_wen;
   logic [31:0] resp_rdata, dram_d, dram_q;
   logic [10:0] dram_a;

   logic        req_ready2, resp_valid2, dram_csn2, dram_rasn2, dram_casn2, dram_wen2;
   logic [31:0] resp_rdata2, dram_d2;
   logic [10:0] dram_a2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dram_ctrl dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .dram_csn(dram_csn),
      .dram_rasn(dram_rasn), .dram_casn(dram_casn), .dram_wen(dram_wen),
      .dram_a(dram_a), .dram_d(dram_d), .dram_q(dram_q)
   );

   dram_ctrl #(.T_RCD(2), .T_CL(3), .T_RP(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid2), .req_ready(req_ready2),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid2), .resp_rdata(resp_rdata2), .dram_csn(dram_csn2),
      .dram_rasn(dram_rasn2), .dram_casn(dram_casn2), .dram_wen(dram_wen2),
      .dram_a(dram_a2), .dram_d(dram_d2), .dram_q(32'h0)
   );

   // Asynchronous-strobe DRAM: row latched on RASn fall, column/write on CASn fall.
   logic [31:0] mem [logic [21:0]];
   logic [10:0] row_lat = '0;
   logic [31:0] q_lat = '0;
   assign dram_q = q_lat;

   always @(negedge dram_rasn) row_lat = dram_a;
   always @(negedge dram_casn) begin
      if (!dram_wen) mem[{row_lat, dram_a}] = dram_d;
      else q_lat = mem.exists({row_lat, dram_a}) ? mem[{row_lat, dram_a}] : 32'h0;
   end

   function automatic logic [31:0] mem_rd(input logic [21:0] key);
      return mem.exists(key) ? mem[key] : 32'h0;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Per-cycle samples, index = cycle number after the accept edge.
   logic [3:0]  s_pins [0:15];
   logic [10:0] s_a [0:15];
   logic [31:0] s_d [0:15];
   logic [31:0] s_rd [0:15];
   logic        s_rv [0:15];
   logic        s_rdy [0:15];
   logic [3:0]  s2_pins [0:15];
   logic [10:0] s2_a [0:15];
   logic        s2_rv [0:15];
   logic        s2_rdy [0:15];

   task automatic sample(input int k);
      s_pins[k] = {dram_csn, dram_rasn, dram_casn, dram_wen};
      s_a[k]    = dram_a;
      s_d[k]    = dram_d;
      s_rd[k]   = resp_rdata;
      s_rv[k]   = resp_valid;
      s_rdy[k]  = req_ready;
      s2_pins[k] = {dram_csn2, dram_rasn2, dram_casn2, dram_wen2};
      s2_a[k]    = dram_a2;
      s2_rv[k]   = resp_valid2;
      s2_rdy[k]  = req_ready2;
   endtask

   task automatic present(input bit sel2, input bit w, input logic [10:0] row,
                          input logic [10:0] col, input logic [31:0] data);
      int n = 0;
      @(negedge clk);
      req_write = w;
      req_addr  = {row, col};
      req_wdata = data;
      if (sel2) req_valid2 = 1'b1;
      else req_valid = 1'b1;
      while (!(sel2 ? req_ready2 : req_ready) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("ready_timeout", 0, 1);
      @(posedge clk);
   endtask

   task automatic run_access(input bit sel2, input bit w, input logic [10:0] row,
                             input logic [10:0] col, input logic [31:0] data);
      present(sel2, w, row, col, data);
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         if (k == 1) begin
            req_valid  = 1'b0;
            req_valid2 = 1'b0;
         end
         sample(k);
      end
   endtask

   initial begin
      bit wen_hi;
      bit rdy_lo;
      int pulses;

      repeat (3) @(negedge clk);
      check("rst_ready", req_ready, 0);
      check("rst_pins", {dram_csn, dram_rasn, dram_casn, dram_wen}, 4'hF);
      check("rst_a_d", {dram_a, dram_d}, 0);
      check("rst_resp", {resp_valid, resp_rdata}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_release_ready", req_ready, 1);

      // Write row 5 col 10 data 20
      run_access(0, 1, 11'd5, 11'd10, 32'd20);
      check("wr_c1_a", s_a[1], 5);
      check("wr_c1_pins", s_pins[1], 4'b0111);
      check("wr_c2_pins", s_pins[2], 4'b0011);
      check("wr_c3_a", s_a[3], 10);
      check("wr_c3_pins", s_pins[3], 4'b0010);
      check("wr_c3_d", s_d[3], 20);
      check("wr_c4_pins", s_pins[4], 4'b0000);
      check("wr_c5_pins", s_pins[5], 4'b0000);
      check("wr_c5_rv", s_rv[5], 0);
      check("wr_c6_rv", s_rv[6], 1);
      check("wr_c6_pins", s_pins[6], 4'hF);
      check("wr_c6_a_d", {s_a[6], s_d[6]}, 0);
      check("wr_c6_rdy", s_rdy[6], 0);
      check("wr_c7_rv", s_rv[7], 0);
      check("wr_c7_rdy", s_rdy[7], 1);
      check("wr_mem", mem_rd({11'd5, 11'd10}), 20);

      // Read it back
      run_access(0, 0, 11'd5, 11'd10, 32'hDEAD);
      wen_hi = 1'b1;
      for (int k = 1; k <= 8; k++) if (!s_pins[k][0]) wen_hi = 1'b0;
      check("rd_wen_high", wen_hi, 1);
      check("rd_c3_d", s_d[3], 0);
      check("rd_c5_rv", s_rv[5], 0);
      check("rd_c6_rv", s_rv[6], 1);
      check("rd_c6_data", s_rd[6], 20);
      check("rd_c7_hold", s_rd[7], 20);

      // req_valid held across two requests: write then read of row 1 col 1
      present(0, 1, 11'd1, 11'd1, 32'hA5);
      rdy_lo = 1'b1;
      pulses = 0;
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         if (k == 1) req_write = 1'b0;
         if (k == 8) req_valid = 1'b0;
         sample(k);
         if (k <= 6 && req_ready) rdy_lo = 1'b0;
         if (resp_valid) pulses++;
      end
      check("b2b_ready_low", rdy_lo, 1);
      check("b2b_c7_ready", s_rdy[7], 1);
      check("b2b_c8_row", {s_rdy[8], s_pins[8], s_a[8]}, {1'b0, 4'b0111, 11'd1});
      check("b2b_pulses", pulses, 2);
      check("b2b_c13_rv", s_rv[13], 1);
      check("b2b_c13_data", s_rd[13], 32'hA5);

      // Reset during second CAS cycle of a write
      present(0, 1, 11'd2, 11'd3, 32'h33);
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         if (k == 1) req_valid = 1'b0;
         if (k == 5) begin
            check("mid_c5_pins", {dram_csn, dram_rasn, dram_casn, dram_wen}, 4'b0000);
            rst_n = 1'b0;
         end
         if (k == 6) begin
            check("mid_rst_pins", {dram_csn, dram_rasn, dram_casn, dram_wen}, 4'hF);
            check("mid_rst_a_d", {dram_a, dram_d}, 0);
            check("mid_rst_resp", {resp_valid, resp_rdata, req_ready}, 0);
            rst_n = 1'b1;
         end
         if (k == 7) begin
            check("mid_post_ready", req_ready, 1);
            check("mid_post_rv", resp_valid, 0);
         end
      end

      // Slower timing instance: T_RCD=2, T_CL=3, T_RP=2
      run_access(1, 1, 11'd3, 11'd4, 32'h44);
      check("t2_c1_pins", s2_pins[1], 4'b0111);
      check("t2_c3_pins", s2_pins[3], 4'b0011);
      check("t2_c4_col", {s2_pins[4], s2_a[4]}, {4'b0010, 11'd4});
      check("t2_c5_pins", s2_pins[5], 4'b0000);
      check("t2_c7_pins", s2_pins[7], 4'b0000);
      check("t2_c7_rv", s2_rv[7], 0);
      check("t2_c8_rv", {s2_rv[8], s2_pins[8]}, {1'b1, 4'hF});
      check("t2_c9_rv_rdy", {s2_rv[9], s2_rdy[9]}, 2'b00);
      check("t2_c10_rdy", s2_rdy[10], 1);

      // Boundary addresses and all-ones data
      run_access(0, 1, 11'h7FF, 11'h7FF, 32'hFFFF_FFFF);
      check("bnd_c1_a", s_a[1], 11'h7FF);
      check("bnd_c3_a_d", {s_a[3], s_d[3]}, {11'h7FF, 32'hFFFF_FFFF});
      run_access(0, 0, 11'h7FF, 11'h7FF, 32'h0);
      check("bnd_rd_max", s_rd[6], 32'hFFFF_FFFF);
      run_access(0, 0, 11'h000, 11'h000, 32'h0);
      check("bnd_rd_zero", {s_rv[6], s_rd[6]}, {1'b1, 32'h0});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
